// File: rtl/mo_pkg.sv
// Shared constants and channel state encoding for the motion-object
// line-buffer address generator.
package mo_pkg;

    localparam int MO_AW       = 8;
    localparam int MO_SRW      = 16;
    localparam int MO_SPR_W    = 16;
    localparam int MO_CHANNELS = 2;

    typedef enum logic {
        MO_IDLE   = 1'b0,
        MO_ACTIVE = 1'b1
    } mo_state_e;

endpackage

// File: rtl/mo_addr_channel.sv
// One line-buffer X counter with a direction latch and a fixed-length
// write window that opens on load.
module mo_addr_channel
    import mo_pkg::*;
#(
    parameter int AW    = MO_AW,
    parameter int SPR_W = MO_SPR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [AW-1:0] start_x,
    input  logic          ld_n,
    input  logic          cl_n,
    input  logic          flip,
    output logic [AW-1:0] addr,
    output logic          wr_win,
    output logic          dir
);

    localparam int RW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [RW-1:0] REM_INIT = RW'(SPR_W - 1);

    mo_state_e     state;
    logic [RW-1:0] remaining;

    assign wr_win = (state == MO_ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            dir       <= 1'b0;
            state     <= MO_IDLE;
            remaining <= '0;
        end else if (ce) begin
            if (!ld_n) begin
                addr      <= start_x;
                dir       <= flip;
                state     <= MO_ACTIVE;
                remaining <= REM_INIT;
            end else if (!cl_n) begin
                addr      <= '0;
                dir       <= 1'b0;
                state     <= MO_IDLE;
                remaining <= '0;
            end else begin
                // Counter keeps scanning even with the window closed.
                addr <= dir ? addr - AW'(1) : addr + AW'(1);
                if (state == MO_ACTIVE) begin
                    if (remaining == '0)
                        state <= MO_IDLE;
                    else
                        remaining <= remaining - RW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mo_line_addr_gen.sv
// Bank of independent motion-object line-buffer address counters
// sharing one start X, pixel enable and flip request.
module mo_line_addr_gen
    import mo_pkg::*;
#(
    parameter int CHANNELS = MO_CHANNELS,
    parameter int AW       = MO_AW,
    parameter int SRW      = MO_SRW,
    parameter int SPR_W    = MO_SPR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic [SRW-1:0]         sr,
    input  logic [CHANNELS-1:0]    ld_n,
    input  logic [CHANNELS-1:0]    cl_n,
    input  logic                   flip,
    output logic [CHANNELS*AW-1:0] addr,
    output logic [CHANNELS-1:0]    wr_win,
    output logic [CHANNELS-1:0]    dir
);

    logic [AW-1:0] start_x;

    assign start_x = sr[SRW-1 -: AW];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mo_addr_channel #(
            .AW    (AW),
            .SPR_W (SPR_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .ce      (ce),
            .start_x (start_x),
            .ld_n    (ld_n[i]),
            .cl_n    (cl_n[i]),
            .flip    (flip),
            .addr    (addr[i*AW +: AW]),
            .wr_win  (wr_win[i]),
            .dir     (dir[i])
        );
    end

endmodule
